// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, multiplier iteration count and FSM states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 64;
    localparam int unsigned MUL_ITER  = 64;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_ITER);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration of the sequential multiplier.
// {c,s} = H + (L[0] ? M : 0); {H,L} next = {c,s,L} >> 1.
module mul_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_h,
    input  logic [WIDTH-1:0] i_l,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_h,
    output logic [WIDTH-1:0] o_l
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    // Single adder with carry-out, then the 2*WIDTH+1 bit right shift.
    always_comb begin
        w_addend = i_l[0] ? i_m : '0;
        w_sum    = {1'b0, i_h} + {1'b0, w_addend};
        o_h      = w_sum[WIDTH:1];
        o_l      = {w_sum[0], i_l[WIDTH-1:1]};
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle WIDTH x WIDTH -> 2*WIDTH multiplier for the EX stage.
// Signed operands are reduced to magnitudes in PREP and the product is
// negated in FIX, so the iteration loop is always unsigned.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo
);

    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(MUL_ITER - 1);

    mul_state_t           r_state;
    mul_state_t           w_state_next;
    logic                 w_accept;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_h;
    logic [WIDTH-1:0]     r_l;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic                 r_neg;
    logic                 r_signed;
    logic [WIDTH-1:0]     w_step_h;
    logic [WIDTH-1:0]     w_step_l;
    logic [2*WIDTH-1:0]   w_fix;

    mul_step #(
        .WIDTH (WIDTH)
    ) u_mul_step (
        .i_h (r_h),
        .i_l (r_l),
        .i_m (r_m),
        .o_h (w_step_h),
        .o_l (w_step_l)
    );

    // 128-bit two's-complement negation of the accumulated product.
    always_comb begin
        w_fix = ~{r_h, r_l} + (2 * WIDTH)'(1);
    end

    // Next-state logic; flush overrides everything, start only taken when idle or done.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (i_flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        w_accept     = 1'b1;
                        w_state_next = PREP;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                PREP:    w_state_next = RUN;
                RUN:     w_state_next = (r_cnt == CNT_LAST) ? FIX : RUN;
                FIX:     w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand, accumulator, counter and sign registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m      <= '0;
            r_h      <= '0;
            r_l      <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
        end else if (i_flush) begin
            r_h   <= '0;
            r_l   <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_m      <= i_op_a;
            r_l      <= i_op_b;
            r_neg    <= i_is_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
            r_signed <= i_is_signed;
        end else begin
            case (r_state)
                PREP: begin
                    // Most-negative value negates to itself, which reads correctly as unsigned.
                    if (r_signed && r_m[WIDTH-1]) begin
                        r_m <= -r_m;
                    end
                    if (r_signed && r_l[WIDTH-1]) begin
                        r_l <= -r_l;
                    end
                    r_h   <= '0;
                    r_cnt <= '0;
                end
                RUN: begin
                    r_h   <= w_step_h;
                    r_l   <= w_step_l;
                    r_cnt <= r_cnt + MUL_CNT_W'(1);
                end
                FIX: begin
                    if (r_neg) begin
                        {r_h, r_l} <= w_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decoded from state only.
    always_comb begin
        o_busy    = (r_state == PREP) || (r_state == RUN) || (r_state == FIX);
        o_done    = (r_state == DONE);
        o_prod_hi = r_h;
        o_prod_lo = r_l;
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed corner cases, back-to-back,
// flush/reset aborts and randomized operands against an arithmetic model.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic        is_signed;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] prod_hi;
    logic [63:0] prod_lo;

    int vectors     = 0;
    int miscompares = 0;

    alu_mul_seq #(
        .WIDTH (64)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_flush     (flush),
        .i_is_signed (is_signed),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .o_busy      (busy),
        .o_done      (done),
        .o_prod_hi   (prod_hi),
        .o_prod_lo   (prod_lo)
    );

    always #5 clk = ~clk;

    // Reference: full-width product of (sign- or zero-) extended operands.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = s ? {{64{a[63]}}, a} : {64'd0, a};
        eb = s ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a start at the current negedge; operands are scrambled afterwards.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        @(negedge clk);
        start     = 1'b0;
        op_a      = {$urandom, $urandom};
        op_b      = {$urandom, $urandom};
        is_signed = 1'($urandom);
    endtask

    // Called at the negedge after the start edge; ends at the DONE-cycle negedge.
    task automatic finish_mul(input string tag, input logic [127:0] exp, input bit noise);
        int n = 0;
        while (!done && n < 100) begin
            check({tag, "_busy"}, 128'(busy), 128'd1);
            if (noise && (n % 13 == 5)) begin
                start     = 1'b1;
                op_a      = {$urandom, $urandom};
                op_b      = {$urandom, $urandom};
                is_signed = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 128'(n), 128'd66);
        check({tag, "_busy_in_done"}, 128'(busy), 128'd0);
        check({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic        s;

        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_prod", {prod_hi, prod_lo}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned max x max, then done must drop after one cycle with product held.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        finish_mul("uu_max", 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
        @(negedge clk);
        check("done_pulse", 128'(done), 128'd0);
        check("prod_hold", {prod_hi, prod_lo}, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        issue(-64'sd3, 64'd7, 1'b1);
        finish_mul("s_m3x7", {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB}, 1'b0);
        @(negedge clk);

        // Most-negative squared, signed then unsigned back-to-back from DONE.
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        finish_mul("s_min2", {64'h4000_0000_0000_0000, 64'd0}, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        finish_mul("u_min2", {64'h4000_0000_0000_0000, 64'd0}, 1'b0);
        @(negedge clk);

        issue(64'd0, 64'h1234, 1'b0);
        finish_mul("zero", 128'd0, 1'b0);
        @(negedge clk);
        issue(64'd1, 64'h8000_0000_0000_0000, 1'b0);
        finish_mul("ident", {64'd0, 64'h8000_0000_0000_0000}, 1'b0);

        // Back-to-back from DONE with starts pulsed while busy.
        issue(64'd5, 64'd6, 1'b0);
        finish_mul("b2b_5x6", 128'd30, 1'b1);

        // Randomized operands, some back-to-back, some with busy-time starts.
        for (int i = 0; i < 12; i++) begin
            a = rnd64();
            b = rnd64();
            s = 1'($urandom);
            if (i % 3 == 0) @(negedge clk);
            issue(a, b, s);
            finish_mul($sformatf("rand%0d", i), ref_mul(a, b, s), 1'(i % 2));
        end
        @(negedge clk);

        // Flush during RUN iteration 20.
        issue(rnd64(), rnd64(), 1'b1);
        repeat (20) @(negedge clk);
        check("pre_flush_busy", 128'(busy), 128'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 128'(busy), 128'd0);
        check("flush_done", 128'(done), 128'd0);
        check("flush_prod", {prod_hi, prod_lo}, 128'd0);
        for (int i = 0; i < 70; i++) begin
            if (done || busy) begin
                check("flush_no_done", {126'd0, busy, done}, 128'd0);
                break;
            end
            @(negedge clk);
        end

        // Flush and start together in IDLE: flush wins.
        start = 1'b1;
        flush = 1'b1;
        op_a  = 64'd9;
        op_b  = 64'd9;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 128'(busy), 128'd0);
        @(negedge clk);
        check("flush_start_busy2", 128'(busy), 128'd0);
        check("flush_start_done", 128'(done), 128'd0);

        // Recovery after flush.
        a = rnd64();
        b = rnd64();
        issue(a, b, 1'b1);
        finish_mul("post_flush", ref_mul(a, b, 1'b1), 1'b0);

        // Asynchronous reset mid-RUN, checked between clock edges.
        issue(64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000, 1'b0);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        check("arst_prod", {prod_hi, prod_lo}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_idle", 128'(busy), 128'd0);

        a = rnd64();
        b = rnd64();
        issue(a, b, 1'b0);
        finish_mul("post_rst", ref_mul(a, b, 1'b0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
